// File: rtl/imem_cache.sv
// imem_cache: direct-mapped, read-only instruction cache with word-serial line refill.
// Hits answer combinationally; a miss walks IDLE -> FILL -> DONE while the fetch stage stalls.
`default_nettype none
module imem_cache #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [13:0] IC_ADDR,
  input  logic        IC_RDEN,
  input  logic        IC_INVALIDATE,
  output logic [31:0] IC_DOUT,
  output logic        IC_HIT,
  output logic        IC_STALL,
  output logic        MEM_REQ,
  output logic [13:0] MEM_ADDR,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_DATA
);
  localparam int OB = $clog2(WORDS_PER_LINE);
  localparam int IB = $clog2(LINES);
  localparam int TB = 14 - IB - OB;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      data_q [LINES*WORDS_PER_LINE];
  logic [TB-1:0]    tag_q  [LINES];
  logic [LINES-1:0] valid_q, valid_d;
  logic [13:0]      base_q, base_d;
  logic [OB-1:0]    beat_q, beat_d;
  logic             pend_q, pend_d;

  logic [OB-1:0] req_off;
  logic [IB-1:0] req_idx;
  logic [TB-1:0] req_tag;
  logic [IB-1:0] fill_idx;
  logic          lookup_hit;
  logic          miss;
  logic          last_beat;
  logic          fill_we;

  assign req_off    = IC_ADDR[OB-1:0];
  assign req_idx    = IC_ADDR[OB+IB-1:OB];
  assign req_tag    = IC_ADDR[13:OB+IB];
  assign fill_idx   = base_q[OB+IB-1:OB];
  assign lookup_hit = IC_RDEN && (state_q == S_IDLE) && valid_q[req_idx]
                      && (tag_q[req_idx] == req_tag);
  assign miss       = IC_RDEN && !lookup_hit;
  assign last_beat  = (beat_q == {OB{1'b1}});

  // FSM: state register
  always_ff @(posedge CLOCK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state; a redirect during FILL never aborts the line
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (miss) state_d = S_FILL;
      S_FILL:  if (MEM_ACK && last_beat) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    IC_HIT   = lookup_hit;
    IC_STALL = IC_RDEN && !lookup_hit;
    IC_DOUT  = data_q[{req_idx, req_off}];
    MEM_REQ  = (state_q == S_FILL);
    MEM_ADDR = (state_q == S_FILL) ? {base_q[13:OB], beat_q} : 14'd0;
  end

  always_comb begin
    valid_d = valid_q;
    base_d  = base_q;
    beat_d  = beat_q;
    pend_d  = pend_q;
    fill_we = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (miss) begin
          base_d           = {IC_ADDR[13:OB], {OB{1'b0}}};
          beat_d           = '0;
          valid_d[req_idx] = 1'b0;
        end
        if (IC_INVALIDATE) valid_d = '0;
      end
      S_FILL: begin
        if (IC_INVALIDATE) pend_d = 1'b1;
        if (MEM_ACK) begin
          fill_we = 1'b1;
          beat_d  = beat_q + OB'(1);
          // A flush that arrived mid-fill must not let this line come back valid
          if (last_beat && !(pend_q || IC_INVALIDATE)) valid_d[fill_idx] = 1'b1;
        end
      end
      S_DONE: begin
        if (pend_q || IC_INVALIDATE) valid_d = '0;
        pend_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      valid_q <= '0;
      base_q  <= '0;
      beat_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (fill_we) begin
      data_q[{fill_idx, beat_q}] <= MEM_DATA;
      if (last_beat) tag_q[fill_idx] <= base_q[13:OB+IB];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_cache.sv
// tb_imem_cache: directed fetch vectors; expected hits and memory addresses go into
// queues that a negedge monitor drains whenever the cache presents a hit or a request.
`default_nettype none
`timescale 1ns/1ps
module tb_imem_cache;
  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic [13:0] IC_ADDR = '0;
  logic        IC_RDEN = 1'b0;
  logic        IC_INVALIDATE = 1'b0;
  logic [31:0] IC_DOUT;
  logic        IC_HIT;
  logic        IC_STALL;
  logic        MEM_REQ;
  logic [13:0] MEM_ADDR;
  logic        MEM_ACK = 1'b1;
  logic [31:0] MEM_DATA;

  always #5 CLOCK = ~CLOCK;

  imem_cache #(.LINES(16), .WORDS_PER_LINE(4)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .IC_ADDR(IC_ADDR), .IC_RDEN(IC_RDEN),
    .IC_INVALIDATE(IC_INVALIDATE), .IC_DOUT(IC_DOUT), .IC_HIT(IC_HIT),
    .IC_STALL(IC_STALL), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR),
    .MEM_ACK(MEM_ACK), .MEM_DATA(MEM_DATA)
  );

  // Backing memory: every word carries its own address in the low bits
  assign MEM_DATA = {16'hDEAD, 2'b00, MEM_ADDR};

  typedef struct {
    logic [13:0] addr;
    logic [31:0] data;
    int          stall;
  } hit_t;

  hit_t        hit_q[$];
  logic [13:0] maddr_q[$];
  int          tests = 0;
  int          fails = 0;
  int          stall_cnt = 0;
  int          ack_stall_left = 0;
  logic [13:0] ack_stall_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory acknowledge driver: withholds ACK for a programmed address and count
  initial begin
    forever begin
      @(posedge CLOCK);
      #1;
      if (MEM_REQ === 1'b1 && MEM_ADDR === ack_stall_addr && ack_stall_left > 0) begin
        MEM_ACK = 1'b0;
        ack_stall_left--;
      end else begin
        MEM_ACK = 1'b1;
      end
    end
  end

  // Monitor
  always @(negedge CLOCK) begin
    hit_t e;
    if (IC_STALL === 1'b1) stall_cnt++;
    if (MEM_REQ === 1'b1) begin
      if (maddr_q.size() == 0) check("unexpected_mem_req", {31'd0, MEM_REQ}, 32'd0);
      else begin
        check("mem_addr", {18'd0, MEM_ADDR}, {18'd0, maddr_q[0]});
        if (MEM_ACK) void'(maddr_q.pop_front());
      end
    end
    if (IC_HIT === 1'b1) begin
      if (hit_q.size() == 0) check("unexpected_hit", {31'd0, IC_HIT}, 32'd0);
      else begin
        e = hit_q.pop_front();
        check("ic_dout", IC_DOUT, e.data);
        check("stall_cycles", stall_cnt, e.stall);
      end
    end
  end

  // Issue one fetch and hold it until the cache hits; inv_cycle selects which cycle pulses IC_INVALIDATE
  task automatic fetch(input logic [13:0] a, input logic [31:0] d, input int stall,
                       input int nfill, input int inv_cycle);
    hit_t e;
    bit   got;
    e.addr = a; e.data = d; e.stall = stall;
    hit_q.push_back(e);
    for (int f = 0; f < nfill; f++)
      for (int w = 0; w < 4; w++) maddr_q.push_back({a[13:2], 2'(w)});
    stall_cnt = 0;
    IC_RDEN = 1'b1;
    IC_ADDR = a;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      IC_INVALIDATE = (k == inv_cycle);
      @(negedge CLOCK);
      if (IC_HIT === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(posedge CLOCK); #1;
    end
    @(posedge CLOCK); #1;
    IC_INVALIDATE = 1'b0;
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL fetch_timeout: addr %h never hit, expected hit after %0d stalls", a, stall);
      hit_q.delete();
      maddr_q.delete();
    end
  endtask

  initial begin
    repeat (2) @(posedge CLOCK);
    #1 RESET = 1'b0;
    @(negedge CLOCK);
    check("reset_hit", {31'd0, IC_HIT}, 32'd0);
    check("reset_stall", {31'd0, IC_STALL}, 32'd0);
    check("reset_mem_req", {31'd0, MEM_REQ}, 32'd0);
    check("reset_mem_addr", {18'd0, MEM_ADDR}, 32'd0);
    @(posedge CLOCK); #1;

    // Cold miss, then the rest of the line hits back to back
    fetch(14'h0010, 32'hDEAD0010, 6, 1, -1);
    fetch(14'h0011, 32'hDEAD0011, 0, 0, -1);
    fetch(14'h0012, 32'hDEAD0012, 0, 0, -1);
    fetch(14'h0013, 32'hDEAD0013, 0, 0, -1);

    // Conflict on index 4
    fetch(14'h0110, 32'hDEAD0110, 6, 1, -1);
    fetch(14'h0010, 32'hDEAD0010, 6, 1, -1);

    // ACK withheld three cycles on beat 1
    fetch(14'h0110, 32'hDEAD0110, 6, 1, -1);
    ack_stall_addr = 14'h0011;
    ack_stall_left = 3;
    fetch(14'h0010, 32'hDEAD0010, 9, 1, -1);

    // Invalidate in IDLE: pulse cycle still hits old contents, next read misses
    fetch(14'h0020, 32'hDEAD0020, 6, 1, -1);
    fetch(14'h0020, 32'hDEAD0020, 0, 0, 0);
    fetch(14'h0020, 32'hDEAD0020, 6, 1, -1);

    // Invalidate during FILL: completed line stays invalid, so the held read refills again
    fetch(14'h0030, 32'hDEAD0030, 12, 2, 2);
    fetch(14'h0020, 32'hDEAD0020, 6, 1, -1);
    fetch(14'h0031, 32'hDEAD0031, 0, 0, -1);

    IC_RDEN = 1'b0;
    @(negedge CLOCK);
    check("idle_no_stall", {31'd0, IC_STALL}, 32'd0);
    check("idle_no_hit", {31'd0, IC_HIT}, 32'd0);
    @(posedge CLOCK); #1;

    // Reset on the second FILL beat
    maddr_q.push_back(14'h0040);
    maddr_q.push_back(14'h0041);
    IC_RDEN = 1'b1;
    IC_ADDR = 14'h0040;
    @(posedge CLOCK); #1;
    @(posedge CLOCK); #1;
    RESET = 1'b1;
    IC_RDEN = 1'b0;
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    @(negedge CLOCK);
    check("abort_mem_req", {31'd0, MEM_REQ}, 32'd0);
    check("abort_mem_addr", {18'd0, MEM_ADDR}, 32'd0);
    check("abort_stall", {31'd0, IC_STALL}, 32'd0);
    @(posedge CLOCK); #1;
    fetch(14'h0040, 32'hDEAD0040, 6, 1, -1);

    IC_RDEN = 1'b0;
    repeat (2) @(posedge CLOCK);
    check("hit_queue_drained", hit_q.size(), 32'd0);
    check("mem_queue_drained", maddr_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_cache.md
# imem_cache

Direct-mapped, read-only instruction cache that answers the fetch stage's instruction-memory read port (word address from PC[15:2], read enable) and refills lines from a slower backing memory over a request/acknowledge word interface. It sits between the fetch-stage program counter and main memory. On a hit it returns the instruction in the same cycle. On a miss it asserts a stall, which the pipeline uses to hold PC_WRITE and IF_ID_Write low until the line is filled.

## Interface
- LINES, 16: number of cache lines; power of two, ≥2
- WORDS_PER_LINE, 4: 32-bit words per line; power of two, ≥2
- CLOCK  in  1  sole clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- IC_ADDR  in  14  word address of requested instruction (PC[15:2])
- IC_RDEN  in  1  read request this cycle
- IC_INVALIDATE  in  1  one-cycle pulse; invalidate all lines (fence.i)
- IC_DOUT  out  32  instruction; meaningful only when IC_HIT=1
- IC_HIT  out  1  combinational: request served this cycle
- IC_STALL  out  1  combinational: IC_RDEN & ~IC_HIT
- MEM_REQ  out  1  backing-memory word read request
- MEM_ADDR  out  14  backing-memory word address
- MEM_ACK  in  1  MEM_DATA valid for MEM_ADDR this cycle
- MEM_DATA  in  32  backing-memory read data

## Operation
- Address split: offset = IC_ADDR[OB-1:0], where OB = log2(WORDS_PER_LINE). Index = next IB = log2(LINES) bits. Tag = remaining 14-IB-OB bits. Defaults: 2 / 4 / 8 bits.
- Storage: data array LINES×WORDS_PER_LINE×32, tag array, and one valid bit per line. Lookup is asynchronous read; writes occur on the clock edge.
- IC_HIT = IC_RDEN & (state==IDLE) & valid[index] & (tag[index]==addr tag). IC_DOUT = data[index][offset] at all times.
- FSM states: IDLE, FILL, DONE.
  - IDLE → FILL: a miss occurs (IC_RDEN=1, IC_HIT=0). Latch line base = {tag,index,0}, clear beat counter, clear valid[index].
  - FILL: MEM_REQ=1 and MEM_ADDR = base + beat. On each MEM_ACK, write MEM_DATA to data[index][beat] and increment beat. On the ack of the last beat, write the tag, set valid[index] (unless an invalidate is pending), and go to DONE.
  - DONE → IDLE unconditionally. IC_HIT=0 in DONE, so IC_STALL stays high for one more cycle.
- MEM_REQ=0 and MEM_ADDR=0 outside FILL.
- IC_RDEN low or IC_ADDR changing during FILL (branch redirect) does not abort the fill. The lookup in IDLE then uses the current address, which may miss again.
- IC_INVALIDATE:
  - In IDLE: clear all valid bits at the next edge. IC_HIT is still evaluated on the old contents in the pulse cycle.
  - In FILL or DONE: set a pending flag. The completing line is not validated, and all valids are cleared on entry to IDLE.
- IC_RDEN=0 in IDLE: no state change, IC_STALL=0.

## Timing
- Reset (synchronous) sets: all valid bits 0, state IDLE, beat 0, pending invalidate 0, MEM_REQ 0, MEM_ADDR 0. IC_HIT=0 and IC_STALL=IC_RDEN follow combinationally. Data and tag arrays are not reset.
- Reset mid-FILL aborts the fill. The line being filled stays invalid, and MEM_REQ drops in the cycle after the reset edge.
- Hit latency: 0 cycles (combinational, same cycle as IC_RDEN).
- Miss penalty with MEM_ACK held high: 1 (IDLE miss) + WORDS_PER_LINE (FILL) + 1 (DONE) = 6 stall cycles for the default configuration. The hit occurs on cycle 7.
- Each additional cycle MEM_ACK is low during FILL adds one stall cycle. MEM_ADDR is stable while MEM_REQ=1 and MEM_ACK=0.
- MEM_ACK outside FILL is ignored.
- Beat counter wraps to 0 after the last beat. The line base is always aligned, so MEM_ADDR never crosses a line.

## Test plan
- After reset, IC_RDEN=1, IC_ADDR=0x0010, MEM_ACK=1 constantly:
  - MEM_ADDR steps 0x0010, 0x0011, 0x0012, 0x0013.
  - IC_STALL is high for exactly 6 cycles.
  - On cycle 7, IC_HIT=1 and IC_DOUT equals the word supplied for 0x0010.
- After that fill, read 0x0011, 0x0012, 0x0013 in consecutive cycles → each hits with 0 stall and returns the correct word. MEM_REQ stays 0.
- Conflict test: fill 0x0010, then read 0x0110 (same index, tag 0x04) → miss and refill from 0x0110. A following read of 0x0010 → miss again.
- Hold MEM_ACK low 3 cycles on beat 1 → MEM_ADDR stays 0x0011 throughout, and total stall is 9 cycles.
- Fill 0x0020, pulse IC_INVALIDATE in IDLE, read 0x0020 → miss. In a second run, pulse IC_INVALIDATE during FILL → the line is not valid after DONE and the read misses.
- Assert RESET on the second FILL beat → state returns to IDLE and MEM_REQ drops. A re-read of the same address performs a full 6-cycle refill.
